div_seq_n: RTL

Sequential, parametrised integer divider for the ALU datapath. It replaces single-cycle combinational division with a radix-2 restoring divider that produces one quotient bit per clock. It takes operands through a start/done handshake and returns the quotient on Y_lo, the remainder on Y_hi, and C/V/N/Z flags. The ALU and control unit stall on `busy` while a divide is in flight.

---
 rtl/div_seq_n.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_seq_n.sv
// Radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// Build option: define DIV_SEQ_SIGNED_EN to compile in two's-complement support.
module div_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_lo,
  output logic [WIDTH-1:0] Y_hi,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  // Handshake: start is accepted only in IDLE (operands captured on that edge);
  // busy is high until done, done pulses one cycle with results valid, and the
  // results hold until overwritten by the next divide. start outside IDLE is dropped.

  state_t           state, state_nx;
  logic [WIDTH-1:0] rem, quo, dvsr, dvnd;
  logic [CW-1:0]    cnt;
  logic             quot_neg, rem_neg, ovf, div_zero;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mag_s, mag_t, q_fix, r_fix;
  logic             neg_q_in, neg_r_in, ovf_in;
  logic             unused_signed;

  assign state_dbg     = state;
  assign unused_signed = signed_op;

  always_comb begin
    mag_s    = S;
    mag_t    = T;
    neg_q_in = 1'b0;
    neg_r_in = 1'b0;
    ovf_in   = 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
    if (signed_op) begin
      if (S[WIDTH-1]) mag_s = -S;
      if (T[WIDTH-1]) mag_t = -T;
      neg_q_in = S[WIDTH-1] ^ T[WIDTH-1];
      neg_r_in = S[WIDTH-1];
      ovf_in   = (S == {1'b1, {(WIDTH-1){1'b0}}}) && (T == '1);
    end
`endif
  end

  // The shifted remainder needs WIDTH+1 bits before the trial subtract.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
  assign q_fix = quot_neg ? -quo : quo;
  assign r_fix = rem_neg  ? -rem : rem;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (T == '0) ? DONE : DIV;
      DIV:     if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y_lo     <= '0;
      Y_hi     <= '0;
      C        <= 1'b0;
      V        <= 1'b0;
      N        <= 1'b0;
      Z        <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      dvnd     <= '0;
      cnt      <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            dvnd     <= S;
            rem      <= '0;
            quo      <= mag_s;
            dvsr     <= mag_t;
            cnt      <= CW'(WIDTH);
            quot_neg <= neg_q_in;
            rem_neg  <= neg_r_in;
            ovf      <= ovf_in;
            div_zero <= (T == '0);
          end
        end
        DIV: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          Y_lo <= q_fix;
          Y_hi <= r_fix;
          N    <= q_fix[WIDTH-1];
          Z    <= (q_fix == '0);
          C    <= 1'b0;
          V    <= ovf;
        end
        DONE: begin
          if (div_zero) begin
            Y_lo <= '1;
            Y_hi <= dvnd;
            V    <= 1'b1;
            C    <= 1'b0;
            N    <= 1'b1;
            Z    <= 1'b0;
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
